// File: rtl/dmem_responder.sv
// Line-granular memory responder for the dcache line interface.
// Each request completes a fixed LATENCY edges after acceptance, with a one-cycle ack.
module dmem_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      addr_i,
  input  logic [255:0]     data_i,
  input  logic             enable_i,
  input  logic             write_i,
  output logic             ack_o,
  output logic [255:0]     data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic [CNT_W-1:0] wr_count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic             accept, done;
  logic [IDX_W-1:0] req_idx;
  logic [255:0]     req_data;
  logic             req_wr;
  logic [255:0]     memory [DEPTH];

  // Offset bits and index bits above DEPTH are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (enable_i) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (cnt == 8'd0) begin
        done      = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      data_o     <= '0;
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 8'd0)
        cnt <= cnt - 8'd1;
      if (done && !req_wr) begin
        data_o     <= memory[req_idx];
        rd_count_o <= sat_inc(rd_count_o);
      end
      if (done && req_wr)
        wr_count_o <= sat_inc(wr_count_o);
    end
  end

  // Request fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_idx  <= addr_i[5 +: IDX_W];
      req_data <= data_i;
      req_wr   <= write_i;
    end
  end

  // Storage has no reset; an aborted request never reaches done.
  always_ff @(posedge clk_i) begin
    if (done && req_wr)
      memory[req_idx] <= req_data;
  end

  assign ack_o  = (state == ACK);
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=10 instance for the main checks
// and a LATENCY=1, CNT_W=2 instance for back-to-back and counter saturation.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [31:0]  addr_a, addr_b;
  logic [255:0] data_a, data_b;
  logic         en_a, en_b, wr_a, wr_b;
  logic         ack_a, ack_b, busy_a, busy_b;
  logic [255:0] dout_a, dout_b;
  logic [15:0]  rdc_a, wrc_a;
  logic [1:0]   rdc_b, wrc_b;

  dmem_responder #(.LATENCY(10), .DEPTH(512), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr_a), .data_i(data_a),
    .enable_i(en_a), .write_i(wr_a), .ack_o(ack_a), .data_o(dout_a),
    .busy_o(busy_a), .rd_count_o(rdc_a), .wr_count_o(wrc_a)
  );

  dmem_responder #(.LATENCY(1), .DEPTH(4), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr_b), .data_i(data_b),
    .enable_i(en_b), .write_i(wr_b), .ack_o(ack_b), .data_o(dout_b),
    .busy_o(busy_b), .rd_count_o(rdc_b), .wr_count_o(wrc_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_data;
    int           exp_rd;
    int           exp_wr;
  } vec_t;

  vec_t vecs[6];

  // Issue one request on instance A; lat = posedges after the accepting edge until ack seen.
  task automatic req_a(input logic w, input logic [31:0] a, input logic [255:0] d,
                       input bit disturb, output int lat, output bit busy_ok);
    @(negedge clk);
    en_a = 1'b1; wr_a = w; addr_a = a; data_a = d;
    @(posedge clk); #1;
    busy_ok = (busy_a === 1'b1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (disturb && i == 3) begin
        addr_a = 32'h20;
        data_a = '1;
      end
      if (ack_a === 1'b1) begin
        lat  = i;
        en_a = 1'b0;
        break;
      end
      if (busy_a !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  saw_ack;
    int  acks;
    int  ack_cyc[5];

    rst_n = 1'b0;
    en_a = 1'b0; wr_a = 1'b0; addr_a = '0; data_a = '0;
    en_b = 1'b0; wr_b = 1'b0; addr_b = '0; data_b = '0;

    u_a.memory[0]   = 256'h5;
    u_a.memory[1]   = 256'h0;
    u_a.memory[2]   = 256'h0;
    u_a.memory[3]   = 256'h33;
    u_a.memory[511] = 256'h1234;
    u_b.memory[0]   = 256'h77;

    repeat (2) @(posedge clk);
    #1;
    chk("reset ack",   {255'b0, ack_a},  256'h0);
    chk("reset busy",  {255'b0, busy_a}, 256'h0);
    chk("reset data",  dout_a,           256'h0);
    chk("reset rdcnt", {240'b0, rdc_a},  256'h0);
    chk("reset wrcnt", {240'b0, wrc_a},  256'h0);
    @(negedge clk) rst_n = 1'b1;

    vecs[0] = '{1'b0, 32'h0000_0000, 256'h0,      256'h5,      1, 0};
    vecs[1] = '{1'b1, 32'h0000_0400, 256'hA5A5,   256'h5,      1, 1};
    vecs[2] = '{1'b0, 32'h0000_041F, 256'h0,      256'hA5A5,   2, 1};
    vecs[3] = '{1'b1, 32'h0000_4020, 256'hBEEF,   256'hA5A5,   2, 2};
    vecs[4] = '{1'b0, 32'h0000_0020, 256'h0,      256'hBEEF,   3, 2};
    vecs[5] = '{1'b0, 32'h0000_3FE0, 256'h0,      256'h1234,   4, 2};

    for (int v = 0; v < 6; v++) begin
      req_a(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 1'b0, lat, bok);
      chk($sformatf("v%0d latency", v), 256'(lat), 256'd10);
      chk($sformatf("v%0d busy", v),    {255'b0, bok}, 256'h1);
      chk($sformatf("v%0d data", v),    dout_a, vecs[v].exp_data);
      chk($sformatf("v%0d rdcnt", v),   {240'b0, rdc_a}, 256'(vecs[v].exp_rd));
      chk($sformatf("v%0d wrcnt", v),   {240'b0, wrc_a}, 256'(vecs[v].exp_wr));
      @(posedge clk); #1;
      chk($sformatf("v%0d ack drop", v),  {255'b0, ack_a},  256'h0);
      chk($sformatf("v%0d busy drop", v), {255'b0, busy_a}, 256'h0);
    end
    chk("mem32 written", u_a.memory[32], 256'hA5A5);
    chk("mem1 wrapped",  u_a.memory[1],  256'hBEEF);

    // Inputs change mid-WAIT; the latched line 2 / CAFE must be used.
    req_a(1'b1, 32'h0000_0040, 256'hCAFE, 1'b1, lat, bok);
    chk("stab latency", 256'(lat), 256'd10);
    chk("stab mem2",    u_a.memory[2], 256'hCAFE);
    chk("stab mem1",    u_a.memory[1], 256'hBEEF);
    chk("stab wrcnt",   {240'b0, wrc_a}, 256'd3);
    @(posedge clk); #1;

    // Reset in the middle of a write to line 3.
    @(negedge clk);
    en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h60; data_a = 256'hDEAD;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; en_a = 1'b0;
    #1;
    chk("rst busy async", {255'b0, busy_a}, 256'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack_a === 1'b1) saw_ack = 1'b1;
    end
    chk("rst no ack", {255'b0, saw_ack}, 256'h0);
    chk("rst mem3",   u_a.memory[3], 256'h33);
    chk("rst busy",   {255'b0, busy_a}, 256'h0);
    chk("rst data",   dout_a, 256'h0);
    chk("rst rdcnt",  {240'b0, rdc_a}, 256'h0);
    chk("rst wrcnt",  {240'b0, wrc_a}, 256'h0);

    // Back-to-back reads on the LATENCY=1 instance with enable held high.
    @(negedge clk);
    en_b = 1'b1; wr_b = 1'b0; addr_b = 32'h0;
    acks = 0;
    for (int c = 1; c <= 40 && acks < 5; c++) begin
      @(posedge clk); #1;
      if (ack_b === 1'b1) begin
        ack_cyc[acks] = c;
        acks++;
        chk($sformatf("b2b rdcnt%0d", acks), {254'b0, rdc_b}, 256'((acks < 3) ? acks : 3));
        if (acks == 1) chk("b2b data", dout_b, 256'h77);
        if (acks == 5) en_b = 1'b0;
      end
    end
    chk("b2b ack count", 256'(acks), 256'd5);
    if (acks == 5) begin
      chk("b2b first ack", 256'(ack_cyc[0]), 256'd2);
      for (int k = 1; k < 5; k++)
        chk($sformatf("b2b spacing%0d", k), 256'(ack_cyc[k] - ack_cyc[k-1]), 256'd3);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b idle",  {255'b0, busy_b}, 256'h0);
    chk("b2b final", {254'b0, rdc_b},  256'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the 256-bit line interface driven by the dcache controller: enable/write request, single-cycle ack.
- Replaces the zero-logic data memory model with a pipelined, latency-parameterised responder. Adds per-request bookkeeping so benches can check the cache's miss/write-back traffic.
- Sits between the CPU's mem_* outputs and backing line storage.

Parameters:
- LATENCY, 10, clock edges from request acceptance to ack_o rising; legal range 1..255.
- DEPTH, 512, number of 256-bit lines stored; power of two.
- CNT_W, 16, width of the read/write request counters.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- addr_i  input  32  byte address of the line; bits [4:0] are ignored.
- data_i  input  256  write line data.
- enable_i  input  1  request valid; held by the initiator until ack_o is seen.
- write_i  input  1  1 = write line, 0 = read line; valid with enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line data; valid while ack_o=1, then held.
- busy_o  output  1  high from acceptance through the ack cycle.
- rd_count_o  output  CNT_W  completed reads, saturating.
- wr_count_o  output  CNT_W  completed writes, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; ack_o=0; busy_o=0; data_o=0; rd_count_o=0; wr_count_o=0; latency counter=0.
  - Line storage is NOT reset; benches preload it hierarchically via the array named memory.
- Line index = addr_i[31:5] modulo DEPTH, i.e. the low log2(DEPTH) bits; higher bits wrap silently.
- IDLE:
  - If enable_i=1 at edge E0, latch index, data_i and write_i; load cnt=LATENCY-1; go to WAIT; busy_o=1.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt≠0, decrement.
  - If cnt==0, go to ACK. On that same edge (E0+LATENCY):
    - write: memory[index] <= latched data; wr_count_o increments.
    - read: data_o <= memory[index]; rd_count_o increments.
    - ack_o <= 1.
  - Inputs are ignored during WAIT. Changes to addr_i, data_i or write_i after acceptance have no effect.
- ACK:
  - ack_o=1 for exactly one cycle; busy_o stays 1.
  - Next edge: ack_o=0, busy_o=0, state=IDLE.
  - enable_i is not sampled in ACK.
- Turnaround:
  - The initiator drops enable_i on the edge that samples ack_o=1, so IDLE sees enable_i=0.
  - If enable_i is still 1 in IDLE, a new request is accepted; back-to-back minimum period = LATENCY+2 cycles.
- data_o on write completion is unchanged (keeps the previous read value).
- Read immediately after a write to the same line returns the written data.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-request: the request is aborted.
  - No memory update unless the ACK edge has already occurred.
  - No ack is issued after reset release.
- LATENCY=1: ack_o rises on edge E0+1.

Test Plan:
- Read latency, LATENCY=10:
  - Stimulus: preload memory[0]=256'h5; assert enable_i=1, write_i=0, addr_i=0 at edge 0.
  - Required: ack_o=1 only in the cycle after edge 10; data_o=...0005; rd_count_o=1; busy_o high in cycles 1..10.
- Write then read:
  - Stimulus: write addr_i=32'h400, data_i=256'hA5A5 (line 32); drop enable_i after ack; then read 32'h41F.
  - Required: memory[32]=256'hA5A5; second ack returns 256'hA5A5; wr_count_o=1, rd_count_o=1.
- Input stability:
  - Stimulus: during WAIT change addr_i to 32'h20 and data_i to all-ones.
  - Required: the original latched line/data is used; memory[1] untouched.
- Wrap-around:
  - Stimulus: DEPTH=512, write addr_i=32'h0000_4020.
  - Required: memory[1] updated (index 513 mod 512).
- Reset mid-request:
  - Stimulus: accept a write to line 3, pull rst_i low at cycle 5 for 2 cycles, release.
  - Required: memory[3] unchanged; no ack_o pulse; all outputs 0.
- Saturation and back-to-back:
  - Stimulus: CNT_W=2, LATENCY=1, five reads with enable_i held high continuously.
  - Required: five ack pulses spaced 3 cycles apart; rd_count_o stops at 3.
